afe_seq_gen: RTL

- Parametrised successor to the fixed-timing AFE control sequencer: generates the IRST/STI -> CLK burst -> SHR -> INTG/DF_SM -> SHS line sequence for a charge-integrating AFE.
- All phase durations are runtime-programmable and latched at start; channel count is a parameter.
- Adds single-shot and continuous frame modes, a line counter, a per-channel sample strobe for the downstream ADC capture logic, and start/stop/busy/done handshakes.
- Sits between the ADC-init/config logic and the AFE pins.

---
 rtl/afe_seq_gen.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/afe_seq_gen.sv
// afe_seq_gen: programmable AFE line sequencer.
// Each line runs IRST/STI -> CLK burst -> SHR -> INTG/DF_SM -> SHS. The
// frame is single-shot or continuous. Every output is registered from the
// current state, so the pins trail the state register by one cycle.
module afe_seq_gen #(
  parameter int CH_NUM = 64,
  parameter int TW     = 16,
  parameter int LW     = 12,
  localparam int CHW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic           CLK_100M,
  input  logic           CLK_RST_N,
  input  logic           start,
  input  logic           stop,
  input  logic           cont_mode,
  input  logic [TW-1:0]  cfg_irst,
  input  logic [TW-1:0]  cfg_sxx,
  input  logic [TW-1:0]  cfg_half_clk,
  input  logic [TW-1:0]  cfg_gap,
  input  logic [TW-1:0]  cfg_intg,
  input  logic [TW-1:0]  cfg_tft,
  input  logic [TW-1:0]  cfg_wait_shs,
  input  logic [TW-1:0]  cfg_end,
  input  logic [LW-1:0]  cfg_lines,
  output logic           AFE_IRST,
  output logic           AFE_STI,
  output logic           AFE_CLK,
  output logic           AFE_SHR,
  output logic           AFE_INTG,
  output logic           AFE_SHS,
  output logic           AFE_DF_SM,
  output logic           sample_stb,
  output logic [CHW-1:0] ch_idx,
  output logic [LW-1:0]  line_idx,
  output logic           busy,
  output logic           frame_done,
  output logic           cfg_err
);
  // Phase lengths are evaluated wide enough that 2*CH_NUM*half plus sums never wrap
  localparam int LENW = TW + $clog2(2*CH_NUM) + 1;

  typedef enum logic [2:0] {S_IDLE, S_IRST, S_CLK, S_SHR, S_INTG, S_SHS} state_t;

  state_t          state, state_nx;
  logic [LENW-1:0] t, t_nx, len;
  logic [LW-1:0]   line, line_nx;
  logic            stop_pend, pend_nx;
  logic [TW-1:0]   hc, hc_nx;
  logic            lv, lv_nx;
  logic [CHW-1:0]  ch, ch_nx;
  logic            accept, fd_nx, phase_end, stop_now, cfg_ok;

  // shadow configuration, frozen for the whole run
  logic [TW-1:0] s_irst, s_sxx, s_half, s_gap, s_intg, s_tft, s_wait, s_end;
  logic [LW-1:0] s_lines;
  logic          s_cont;

  // Config validity: durations nonzero, strobes nested inside their windows
  always_comb begin
    cfg_ok = (cfg_irst != '0) && (cfg_sxx != '0) && (cfg_half_clk != '0) &&
             (cfg_gap != '0) && (cfg_intg != '0) && (cfg_tft != '0) &&
             (cfg_wait_shs != '0) && (cfg_end != '0) && (cfg_lines != '0) &&
             (cfg_sxx <= cfg_irst) && (cfg_tft <= cfg_intg);
  end

  // Length of the phase currently running
  always_comb begin
    len = LENW'(1);
    case (state)
      S_IRST: len = LENW'(s_irst);
      S_CLK:  len = LENW'(s_half) * LENW'(2*CH_NUM);
      S_SHR:  len = LENW'(s_sxx) + LENW'(s_gap);
      S_INTG: len = LENW'(s_intg) + LENW'(s_wait);
      S_SHS:  len = LENW'(s_sxx) + LENW'(s_end);
      default: len = LENW'(1);
    endcase
  end

  assign phase_end = (t == len - LENW'(1));
  assign stop_now  = stop_pend | stop;

  // Next-state, phase counter, clock divider and line bookkeeping
  always_comb begin
    state_nx = state;
    t_nx     = t;
    line_nx  = line;
    pend_nx  = stop_pend | (stop && (state != S_IDLE));
    hc_nx    = hc;
    lv_nx    = lv;
    ch_nx    = ch;
    accept   = 1'b0;
    fd_nx    = 1'b0;
    if (state == S_IDLE) begin
      pend_nx = 1'b0;
      if (start && cfg_ok) begin
        state_nx = S_IRST;
        t_nx     = '0;
        line_nx  = '0;
        accept   = 1'b1;
      end
    end else begin
      t_nx = t + LENW'(1);
      if (state == S_CLK) begin
        if (hc == s_half - TW'(1)) begin
          hc_nx = '0;
          lv_nx = ~lv;
          if (!lv) ch_nx = ch + CHW'(1);
        end else begin
          hc_nx = hc + TW'(1);
        end
      end
      if (phase_end) begin
        t_nx = '0;
        case (state)
          S_IRST: begin
            state_nx = S_CLK;
            hc_nx    = '0;
            lv_nx    = 1'b1;
            ch_nx    = '0;
          end
          S_CLK:  state_nx = S_SHR;
          S_SHR:  state_nx = S_INTG;
          S_INTG: state_nx = S_SHS;
          S_SHS: begin
            if (line == s_lines - LW'(1)) begin
              fd_nx    = 1'b1;
              line_nx  = '0;
              state_nx = (s_cont && !stop_now) ? S_IRST : S_IDLE;
            end else if (stop_now) begin
              line_nx  = '0;
              state_nx = S_IDLE;
            end else begin
              line_nx  = line + LW'(1);
              state_nx = S_IRST;
            end
            if (state_nx == S_IDLE) pend_nx = 1'b0;
          end
          default: state_nx = S_IDLE;
        endcase
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
    if (!CLK_RST_N) begin
      state     <= S_IDLE;
      t         <= '0;
      line      <= '0;
      stop_pend <= 1'b0;
      hc        <= '0;
      lv        <= 1'b0;
      ch        <= '0;
    end else begin
      state     <= state_nx;
      t         <= t_nx;
      line      <= line_nx;
      stop_pend <= pend_nx;
      hc        <= hc_nx;
      lv        <= lv_nx;
      ch        <= ch_nx;
    end
  end

  // Capture configuration and mode on start acceptance only
  always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
    if (!CLK_RST_N) begin
      s_irst <= '0; s_sxx <= '0; s_half <= '0; s_gap <= '0;
      s_intg <= '0; s_tft <= '0; s_wait <= '0; s_end <= '0;
      s_lines <= '0; s_cont <= 1'b0;
    end else if (accept) begin
      s_irst <= cfg_irst; s_sxx <= cfg_sxx; s_half <= cfg_half_clk;
      s_gap  <= cfg_gap;  s_intg <= cfg_intg; s_tft <= cfg_tft;
      s_wait <= cfg_wait_shs; s_end <= cfg_end;
      s_lines <= cfg_lines; s_cont <= cont_mode;
    end
  end

  // Registered pin and status decode of the current state/phase position
  always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
    if (!CLK_RST_N) begin
      AFE_IRST   <= 1'b0;
      AFE_STI    <= 1'b0;
      AFE_CLK    <= 1'b0;
      AFE_SHR    <= 1'b0;
      AFE_INTG   <= 1'b0;
      AFE_SHS    <= 1'b0;
      AFE_DF_SM  <= 1'b1;
      sample_stb <= 1'b0;
      ch_idx     <= '0;
      line_idx   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      AFE_IRST   <= (state == S_IRST);
      AFE_STI    <= (state == S_IRST) && (t < LENW'(s_sxx));
      AFE_CLK    <= (state == S_CLK) && lv;
      AFE_SHR    <= (state == S_SHR) && (t < LENW'(s_sxx));
      AFE_INTG   <= (state == S_INTG) && (t < LENW'(s_intg));
      AFE_SHS    <= (state == S_SHS) && (t < LENW'(s_sxx));
      AFE_DF_SM  <= !((state == S_INTG) && (t < LENW'(s_tft)));
      sample_stb <= (state == S_CLK) && lv && (hc == '0);
      ch_idx     <= ch;
      line_idx   <= line;
      busy       <= (state != S_IDLE);
      frame_done <= fd_nx;
      cfg_err    <= (state == S_IDLE) && !cfg_ok;
    end
  end

endmodule
